bcd_decoder: RTL and testbench
==============================

# bcd_decoder

Sequential BCD-to-binary converter: it takes four captured decimal digits (thousands, hundreds, tens, ones) and produces an (L+1)-bit binary value. It is the inverse of the display-digit encoder and sits between digit-entry logic (keypad/EEPROM-stored settings) and binary consumers such as ADC thresholds and I2C payload registers. It uses an iterative multiply-by-10 accumulate, one digit per clock, with a start/done handshake and error and overflow flags.

## Interface
- L, 7: output width is L+1 bits; legal range 3..13.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  conversion request; sampled on clk edge.
- inThousand  in  4  BCD thousands digit.
- inHundred  in  4  BCD hundreds digit.
- inTen  in  4  BCD tens digit.
- inOne  in  4  BCD ones digit.
- busy  out  1  high while accumulating.
- done  out  1  one-cycle pulse; results valid and updated in this cycle.
- value  out  L+1  converted binary result; holds until the next done.
- badDigit  out  1  last conversion had a digit >9; holds until the next done.
- overflow  out  1  last conversion exceeded 2^(L+1)-1; holds until the next done.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge:
  - capture all four digits into internal registers;
  - clear the 15-bit accumulator acc;
  - set the digit index to thousands;
  - go to ACCUM.
- ACCUM (exactly 4 edges): each edge computes acc <= (acc<<3)+(acc<<1)+digit[idx].
  - Digit order: thousands, hundreds, tens, ones.
  - The accumulator is 15 bits, so no internal wrap occurs even with illegal digits (max 16665).
  - After the ones digit, go to DONE.
  - start is ignored in ACCUM. Input digits may change freely after capture.
- DONE: done=1 for this one cycle. value, badDigit and overflow are registered on the edge entering DONE:
  - any captured digit >9: badDigit=1, overflow=0, value=0;
  - else if acc > 2^(L+1)-1: overflow=1, badDigit=0, value = all ones (saturate);
  - else: value=acc[L:0], both flags 0.
- DONE transitions:
  - start=1 at the edge leaving DONE: the new conversion is accepted exactly as from IDLE (captured, goes to ACCUM), giving back-to-back throughput.
  - otherwise: go to IDLE.
- badDigit takes precedence over overflow.

## Timing
- Reset (async, immediate): state=IDLE, busy=0, done=0, value=0, badDigit=0, overflow=0; digit registers, acc and index are cleared.
- Reset asserted mid-conversion aborts it. No done is produced, and prior results are cleared to 0.
- Latency, with start sampled at edge E0:
  - busy=1 after E0 through E4;
  - digits are accumulated at E1..E4;
  - done=1 and results are valid after E4, during the cycle before E5.
  - Start-to-done is 5 edges.
- Throughput: one conversion per 5 cycles when start is held high or re-asserted in DONE.
- busy and done are never high simultaneously.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.

## Test plan
- L=7, digits 0,2,5,5, start pulse at E0 -> busy high E0..E4; done pulse after E4; value=255, badDigit=0, overflow=0.
- L=7, digits 0,2,5,6 -> overflow=1, value=255, badDigit=0. Then digits 0,0,0,0 -> value=0, overflow clears at done.
- L=7, digits 0,1,0xA,3 -> badDigit=1, overflow=0, value=0. Also L=7, digits 9,9,9,0xF -> badDigit=1, overflow=0 (precedence).
- L=13, digits 9,9,9,9 -> value=9999, overflow=0. Change the input digits during ACCUM -> result is still 9999.
- start re-pulsed during ACCUM -> ignored, single done. start held high for 15 cycles -> done pulses every 5 cycles.
- rst asserted asynchronously at E2 of a conversion -> outputs immediately 0, no done. Conversion after release completes normally.

Source files
------------

// File: rtl/bcd_decoder_if.sv
// rtl/bcd_decoder_if.sv - start/done handshake and digit/result bundle for bcd_decoder
interface bcd_decoder_if #(
  parameter int L = 7
);
  // Request side: conversion strobe and the four BCD digits.
  logic         start;
  logic [3:0]   inThousand;
  logic [3:0]   inHundred;
  logic [3:0]   inTen;
  logic [3:0]   inOne;

  // Result side: status and the converted value with its flags.
  logic         busy;
  logic         done;
  logic [L:0]   value;
  logic         badDigit;
  logic         overflow;

  // Digit-entry logic drives requests and observes results.
  modport master (
    output start,
    output inThousand,
    output inHundred,
    output inTen,
    output inOne,
    input  busy,
    input  done,
    input  value,
    input  badDigit,
    input  overflow
  );

  // The converter consumes requests and produces results.
  modport slave (
    input  start,
    input  inThousand,
    input  inHundred,
    input  inTen,
    input  inOne,
    output busy,
    output done,
    output value,
    output badDigit,
    output overflow
  );
endinterface

// File: rtl/bcd_decoder.sv
// rtl/bcd_decoder.sv - four-digit BCD to binary converter, one digit per clock
module bcd_decoder #(
  // Result width is L+1 bits; meaningful for L in 3..13 so the 15-bit
  // accumulator always holds the largest possible four-digit value.
  parameter int L = 7
) (
  input  logic         clk,
  input  logic         rst,
  bcd_decoder_if.slave bus
);

  localparam int W = L + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;

  // Captured digits, so the inputs may change once a conversion starts.
  logic [3:0]  thou_q, thou_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  ten_q,  ten_d;
  logic [3:0]  one_q,  one_d;

  // 15 bits is enough for 15*1000+15*100+15*10+15 = 16665, so even
  // illegal digits never wrap before the range check.
  logic [14:0] acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;

  // Results hold from one done to the next.
  logic [L:0]  value_q, value_d;
  logic        bad_q,   bad_d;
  logic        ovf_q,   ovf_d;

  // Datapath helpers.
  logic [3:0]  digit;
  logic [14:0] acc_mac;
  logic        bad_any;
  logic        ovf_any;

  // Select the digit for the current step, thousands first.
  always_comb begin
    digit = one_q;
    unique case (idx_q)
      2'd0:    digit = thou_q;
      2'd1:    digit = hund_q;
      2'd2:    digit = ten_q;
      default: digit = one_q;
    endcase
  end

  // Multiply-by-ten as two shifts plus an add; the digit range and
  // overflow checks look at the value about to be latched.
  always_comb begin
    acc_mac = (acc_q << 3) + (acc_q << 1) + {11'd0, digit};
    bad_any = (thou_q > 4'd9) | (hund_q > 4'd9) |
              (ten_q  > 4'd9) | (one_q  > 4'd9);
    ovf_any = (acc_mac >> W) != 15'd0;
  end

  // Next-state and register-update logic for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    thou_d  = thou_q;
    hund_d  = hund_q;
    ten_d   = ten_q;
    one_d   = one_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    value_d = value_q;
    bad_d   = bad_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request just like IDLE, giving one
        // conversion every five cycles when start stays high.
        if (bus.start) begin
          thou_d  = bus.inThousand;
          hund_d  = bus.inHundred;
          ten_d   = bus.inTen;
          one_d   = bus.inOne;
          acc_d   = 15'd0;
          idx_d   = 2'd0;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end

      ACCUM: begin
        // start is deliberately not looked at here.
        acc_d = acc_mac;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          if (bad_any) begin
            // An illegal digit outranks overflow.
            value_d = '0;
            bad_d   = 1'b1;
            ovf_d   = 1'b0;
          end else if (ovf_any) begin
            value_d = '1;
            bad_d   = 1'b0;
            ovf_d   = 1'b1;
          end else begin
            value_d = acc_mac[L:0];
            bad_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion and clears results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      thou_q  <= 4'd0;
      hund_q  <= 4'd0;
      ten_q   <= 4'd0;
      one_q   <= 4'd0;
      acc_q   <= 15'd0;
      idx_q   <= 2'd0;
      value_q <= '0;
      bad_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      thou_q  <= thou_d;
      hund_q  <= hund_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      bad_q   <= bad_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status decodes straight from the state register, so busy and done
  // are mutually exclusive and free of input-to-output paths.
  assign bus.busy     = (state_q == ACCUM);
  assign bus.done     = (state_q == DONE);
  assign bus.value    = value_q;
  assign bus.badDigit = bad_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_decoder.sv
// tb/tb_bcd_decoder.sv - directed self-checking bench for bcd_decoder
module tb_bcd_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bcd_decoder_if #(.L(7))  ia ();
  bcd_decoder_if #(.L(13)) ib ();

  bcd_decoder #(.L(7)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  bcd_decoder #(.L(13)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [3:0] d3, input logic [3:0] d2,
                       input logic [3:0] d1, input logic [3:0] d0);
    ia.inThousand = d3;
    ia.inHundred  = d2;
    ia.inTen      = d1;
    ia.inOne      = d0;
  endtask

  // Full conversion on the L=7 instance with result checks after E4.
  task automatic conv_a(input string tag,
                        input logic [3:0] d3, input logic [3:0] d2,
                        input logic [3:0] d1, input logic [3:0] d0,
                        input logic [31:0] ev, input logic eb, input logic eo);
    set_a(d3, d2, d1, d0);
    ia.start = 1'b1;
    tick;                                   // E0
    ia.start = 1'b0;
    check({tag, ".busy_e0"}, 32'(ia.busy), 32'd1);
    repeat (3) tick;                        // E1..E3
    check({tag, ".busy_e3"}, 32'(ia.busy), 32'd1);
    tick;                                   // E4
    check({tag, ".done"},  32'(ia.done),     32'd1);
    check({tag, ".busy"},  32'(ia.busy),     32'd0);
    check({tag, ".value"}, 32'(ia.value),    ev);
    check({tag, ".bad"},   32'(ia.badDigit), 32'(eb));
    check({tag, ".ovf"},   32'(ia.overflow), 32'(eo));
    tick;                                   // E5
    check({tag, ".done_e5"}, 32'(ia.done),  32'd0);
    check({tag, ".hold"},    32'(ia.value), ev);
  endtask

  initial begin : stim
    logic [14:0] done_mask;
    logic        overlap;

    ia.start = 1'b0; set_a(4'd0, 4'd0, 4'd0, 4'd0);
    ib.start = 1'b0;
    ib.inThousand = 4'd0; ib.inHundred = 4'd0; ib.inTen = 4'd0; ib.inOne = 4'd0;

    // Reset state on both widths.
    #2;
    check("rst.a.busy",  32'(ia.busy),     32'd0);
    check("rst.a.done",  32'(ia.done),     32'd0);
    check("rst.a.value", 32'(ia.value),    32'd0);
    check("rst.a.bad",   32'(ia.badDigit), 32'd0);
    check("rst.a.ovf",   32'(ia.overflow), 32'd0);
    check("rst.b.value", 32'(ib.value),    32'd0);
    check("rst.b.busy",  32'(ib.busy),     32'd0);
    tick;
    rst = 1'b0;
    tick;

    // Largest in-range value for 8 bits, then first overflow, then zero.
    conv_a("c255", 4'd0, 4'd2, 4'd5, 4'd5, 32'd255, 1'b0, 1'b0);
    conv_a("c256", 4'd0, 4'd2, 4'd5, 4'd6, 32'd255, 1'b0, 1'b1);
    conv_a("c000", 4'd0, 4'd0, 4'd0, 4'd0, 32'd0,   1'b0, 1'b0);

    // Illegal digits, including badDigit beating overflow.
    conv_a("c1A3", 4'd0, 4'd1, 4'hA, 4'd3, 32'd0, 1'b1, 1'b0);
    conv_a("c99F", 4'd9, 4'd9, 4'd9, 4'hF, 32'd0, 1'b1, 1'b0);

    // 14-bit instance: 9999 fits; digits change after capture.
    ib.inThousand = 4'd9; ib.inHundred = 4'd9; ib.inTen = 4'd9; ib.inOne = 4'd9;
    ib.start = 1'b1;
    tick;                                   // E0
    ib.start = 1'b0;
    ib.inThousand = 4'd1; ib.inHundred = 4'd2; ib.inTen = 4'd3; ib.inOne = 4'd4;
    tick;
    ib.inThousand = 4'hF; ib.inOne = 4'd0;
    repeat (3) tick;                        // E4
    check("b9999.done",  32'(ib.done),     32'd1);
    check("b9999.value", 32'(ib.value),    32'd9999);
    check("b9999.ovf",   32'(ib.overflow), 32'd0);
    check("b9999.bad",   32'(ib.badDigit), 32'd0);
    tick;

    // start re-pulsed during ACCUM is ignored: one done only.
    set_a(4'd0, 4'd0, 4'd1, 4'd7);
    ia.start = 1'b1;
    tick;                                   // E0
    ia.start = 1'b0;
    tick;                                   // E1
    ia.start = 1'b1;
    set_a(4'd0, 4'd0, 4'd9, 4'd9);
    tick;                                   // E2
    ia.start = 1'b0;
    tick;                                   // E3
    tick;                                   // E4
    check("rep.done",  32'(ia.done),  32'd1);
    check("rep.value", 32'(ia.value), 32'd17);
    tick;
    tick;
    check("rep.idle_busy", 32'(ia.busy), 32'd0);
    check("rep.idle_done", 32'(ia.done), 32'd0);

    // start held for 15 edges: done after E4, E9 and E14.
    set_a(4'd0, 4'd0, 4'd4, 4'd2);
    ia.start  = 1'b1;
    done_mask = '0;
    overlap   = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      done_mask[i] = ia.done;
      if (ia.done && ia.busy) overlap = 1'b1;
    end
    ia.start = 1'b0;
    check("b2b.mask",    32'(done_mask), 32'h4210);
    check("b2b.overlap", 32'(overlap),   32'd0);
    check("b2b.value",   32'(ia.value),  32'd42);
    tick;
    check("b2b.idle", 32'(ia.busy | ia.done), 32'd0);

    // Reset mid-conversion after a non-zero flagged result.
    conv_a("pre", 4'd0, 4'd3, 4'd0, 4'd0, 32'd255, 1'b0, 1'b1);
    set_a(4'd0, 4'd1, 4'd0, 4'd0);
    ia.start = 1'b1;
    tick;                                   // E0
    ia.start = 1'b0;
    tick;                                   // E1
    tick;                                   // E2
    #2 rst = 1'b1;
    #1;
    check("arst.value", 32'(ia.value),    32'd0);
    check("arst.ovf",   32'(ia.overflow), 32'd0);
    check("arst.busy",  32'(ia.busy),     32'd0);
    check("arst.done",  32'(ia.done),     32'd0);
    tick;
    rst = 1'b0;
    tick;
    tick;
    check("arst.nodone", 32'(ia.done | ia.busy), 32'd0);
    conv_a("c123", 4'd0, 4'd1, 4'd2, 4'd3, 32'd123, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
